// File: rtl/inv_skid_stage.sv
// Two-entry skid buffer that captures A ^ INV_A and presents it on registered outputs.
// Optional push counter enabled by defining INV_SKID_STAGE_STATS_EN.
module inv_skid_stage #(
  parameter int              WIDTH = 2,
  parameter logic [WIDTH-1:0] INV_A = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  (* invertible_pin = "INV_A" *)
  input  logic [WIDTH-1:0] A,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready
`ifdef INV_SKID_STAGE_STATS_EN
  ,
  output logic [15:0]      push_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_fix;
  logic             push, pop;

  assign a_fix = A ^ INV_A;
  assign push  = in_valid && in_ready_q;
  assign pop   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          main_d  = a_fix;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_d  = a_fix;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          main_d = a_fix;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake outputs are registered from the next state so out_ready never reaches in_ready combinationally.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Y         = main_q;

`ifdef INV_SKID_STAGE_STATS_EN
  logic [15:0] push_cnt_q, push_cnt_d;

  always_comb begin
    push_cnt_d = push_cnt_q;
    if (push && (push_cnt_q != 16'hFFFF)) push_cnt_d = push_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) push_cnt_q <= '0;
    else     push_cnt_q <= push_cnt_d;
  end

  assign push_cnt = push_cnt_q;
`endif

endmodule

// File: tb/tb_inv_skid_stage.sv
// Directed bench for inv_skid_stage: two instances (INV_A=0 and INV_A=2'b01) share stimulus.
// Define INV_SKID_STAGE_STATS_EN to also exercise the push counter.
module tb_inv_skid_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a;
  logic       in_valid;
  logic       out_ready;

  logic       ir_a, ov_a, ir_b, ov_b;
  logic [1:0] y_a, y_b;
`ifdef INV_SKID_STAGE_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inv_skid_stage #(.WIDTH(2), .INV_A(2'b00)) dut_a (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .in_ready(ir_a),
    .Y(y_a), .out_valid(ov_a), .out_ready(out_ready)
`ifdef INV_SKID_STAGE_STATS_EN
    , .push_cnt(cnt_a)
`endif
  );

  inv_skid_stage #(.WIDTH(2), .INV_A(2'b01)) dut_b (
    .clk(clk), .rst(rst), .A(a), .in_valid(in_valid), .in_ready(ir_b),
    .Y(y_b), .out_valid(ov_b), .out_ready(out_ready)
`ifdef INV_SKID_STAGE_STATS_EN
    , .push_cnt(cnt_b)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 2'b11; out_ready = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b want 0", ov_a, ov_b); end
    checks++;
    if (ir_a !== 1'b1 || ir_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b/%b want 1", ir_a, ir_b); end
    checks++;
    if (y_a !== 2'b00 || y_b !== 2'b00) begin errors++; $display("FAIL reset_y got %b/%b want 00", y_a, y_b); end
    cyc();
    checks++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL reset_edge_push got %b/%b want 0", ov_a, ov_b); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; a = 2'b10; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (y_b !== 2'b11 || y_a !== 2'b10) begin errors++; $display("FAIL basic_y got %b/%b want 10/11", y_a, y_b); end
    checks++;
    if (ov_a !== 1'b1 || ov_b !== 1'b1 || ir_a !== 1'b1) begin errors++; $display("FAIL basic_flags got ov=%b/%b ir=%b want 1/1/1", ov_a, ov_b, ir_a); end
    cyc();
    checks++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL basic_drain got %b/%b want 0", ov_a, ov_b); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; a = 2'b00;
    cyc();
    checks++;
    if (ov_a !== 1'b1 || ir_a !== 1'b1 || y_a !== 2'b00) begin errors++; $display("FAIL bp_one got ov=%b ir=%b y=%b want 1 1 00", ov_a, ir_a, y_a); end
    a = 2'b01;
    cyc();
    checks++;
    if (ir_a !== 1'b0 || ir_b !== 1'b0 || y_a !== 2'b00) begin errors++; $display("FAIL bp_full got ir=%b/%b y=%b want 0/0 00", ir_a, ir_b, y_a); end
    a = 2'b11;
    cyc();
    cyc();
    checks++;
    if (ir_a !== 1'b0 || ov_a !== 1'b1 || y_a !== 2'b00 || y_b !== 2'b01) begin errors++; $display("FAIL bp_hold got ir=%b ov=%b y=%b/%b want 0 1 00/01", ir_a, ov_a, y_a, y_b); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    checks++;
    if (y_a !== 2'b01 || y_b !== 2'b00 || ov_a !== 1'b1 || ir_a !== 1'b1) begin errors++; $display("FAIL bp_second got y=%b/%b ov=%b ir=%b want 01/00 1 1", y_a, y_b, ov_a, ir_a); end
    cyc();
    checks++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL bp_third_ignored got ov=%b/%b want 0", ov_a, ov_b); end
  endtask

  task automatic test_simul();
    out_ready = 1'b0; in_valid = 1'b1; a = 2'b01;
    cyc();
    a = 2'b11; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (y_a !== 2'b11 || y_b !== 2'b10) begin errors++; $display("FAIL simul_y got %b/%b want 11/10", y_a, y_b); end
    checks++;
    if (ov_a !== 1'b1 || ir_a !== 1'b1) begin errors++; $display("FAIL simul_flags got ov=%b ir=%b want 1 1", ov_a, ir_a); end
    cyc();
    checks++;
    if (ov_a !== 1'b0) begin errors++; $display("FAIL simul_drain got ov=%b want 0", ov_a); end
  endtask

  task automatic test_reset_full();
    int stale;
    out_ready = 1'b0; in_valid = 1'b1; a = 2'b10;
    cyc();
    a = 2'b01;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (ir_a !== 1'b0) begin errors++; $display("FAIL rf_full got ir=%b want 0", ir_a); end
    rst = 1'b1; out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (ov_a !== 1'b0 || ir_a !== 1'b1 || y_a !== 2'b00 || y_b !== 2'b00) begin errors++; $display("FAIL rf_state got ov=%b ir=%b y=%b/%b want 0 1 00/00", ov_a, ir_a, y_a, y_b); end
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (ov_a !== 1'b0 || ov_b !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rf_stale got %0d valid cycles want 0", stale); end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [1:0] w;
    bad = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = 2'(i);
      a = w;
      cyc();
      if (y_a !== w || y_b !== (w ^ 2'b01) || ov_a !== 1'b1 || ir_a !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL back_to_back got %0d bad cycles want 0", bad); end
    cyc();
  endtask

  task automatic test_stream();
    logic [1:0] q[$];
    int sent, recv, cyc_n;
    logic push, pop;
    sent = 0; recv = 0; cyc_n = 0;
    q.delete();
    while (recv < 1000 && cyc_n < 20000) begin
      in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a         = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      checks++;
      if (ov_a !== (q.size() != 0) || ir_a !== (q.size() < 2) || ov_b !== ov_a) begin
        errors++; $display("FAIL stream_flags got ov=%b ir=%b want ov=%0d ir=%0d", ov_a, ir_a, q.size() != 0, q.size() < 2);
      end
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() != 0);
      if (pop) begin
        checks++;
        if (y_a !== q[0] || y_b !== (q[0] ^ 2'b01)) begin
          errors++; $display("FAIL stream_data got %b/%b want %b/%b", y_a, y_b, q[0], q[0] ^ 2'b01);
        end
        void'(q.pop_front());
        recv++;
      end
      if (push) begin
        q.push_back(a);
        sent++;
      end
      cyc();
      cyc_n++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 1000) begin errors++; $display("FAIL stream_timeout got %0d words want 1000", recv); end
  endtask

`ifdef INV_SKID_STAGE_STATS_EN
  task automatic test_counter();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (cnt_a !== 16'd0) begin errors++; $display("FAIL cnt_reset got %h want 0000", cnt_a); end
    in_valid = 1'b1; out_ready = 1'b1; a = 2'b01;
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (cnt_a !== 16'd5) begin errors++; $display("FAIL cnt_five got %h want 0005", cnt_a); end
    for (int i = 5; i < 70000; i++) cyc();
    checks++;
    if (cnt_a !== 16'hFFFF || cnt_b !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h/%h want ffff", cnt_a, cnt_b); end
    cyc();
    cyc();
    checks++;
    if (cnt_a !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold got %h want ffff", cnt_a); end
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (cnt_a !== 16'd0) begin errors++; $display("FAIL cnt_clear got %h want 0000", cnt_a); end
  endtask
`endif

  initial begin
    rst = 1'b0; a = 2'b00; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_simul();
    test_reset_full();
    test_back_to_back();
    test_stream();
`ifdef INV_SKID_STAGE_STATS_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_skid_stage.md
INV_SKID_STAGE -- requirements
Module: inv_skid_stage

Interface
- REQ-001 SHALL have parameter WIDTH, default 2: data width in bits, legal range 1..32.
- REQ-002 SHALL have parameter INV_A, default {WIDTH{1'b0}}: per-bit inversion mask applied to A at capture.
- REQ-003 SHALL carry the attribute invertible_pin="INV_A" on port A, so the integrateinv pass can absorb an upstream $_NOT_ into INV_A.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 SHALL have port A, input, WIDTH bits: upstream data.
- REQ-007 SHALL have port in_valid, input, 1 bit: A is valid this cycle.
- REQ-008 SHALL have port in_ready, output, 1 bit: the stage accepts A this cycle.
- REQ-009 SHALL have port Y, output, WIDTH bits: registered, inversion-corrected data to the downstream box.
- REQ-010 SHALL have port out_valid, output, 1 bit: Y holds a word.
- REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes Y this cycle.

Function
- REQ-012 SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL, using a main register and a skid register.
- REQ-013 SHALL perform a push when in_valid && in_ready, and a pop when out_valid && out_ready.
- REQ-014 SHALL capture A ^ INV_A on a push; inversion is applied once, at capture only.
- REQ-015 SHALL drive in_ready = (state != FULL) from a register, with no combinational path from out_ready.
- REQ-016 SHALL drive out_valid = (state != EMPTY) and Y = main register, both directly from flops.
- REQ-017 SHALL have one-cycle latency: a word pushed at edge N appears on Y with out_valid=1 after edge N.
- REQ-018 SHALL make these transitions from EMPTY:
  - push -> ONE, load main.
  - otherwise stay in EMPTY.
- REQ-019 SHALL make these transitions from ONE:
  - push with no pop -> FULL, load skid.
  - pop with no push -> EMPTY.
  - push and pop together -> stay in ONE, load main with the new word.
  - neither -> stay in ONE.
- REQ-020 SHALL make these transitions from FULL:
  - pop -> ONE, copy skid into main.
  - otherwise stay in FULL.
  - No push is possible in FULL (in_ready=0).
- REQ-021 SHALL keep Y stable while out_valid=1 and out_ready=0.
- REQ-022 SHALL preserve word order; no word is ever dropped or duplicated.
- REQ-023 SHALL ignore in_valid in FULL; A is not sampled.

Reset
- REQ-024 SHALL, on rst=1 at a rising edge, enter EMPTY with out_valid=0, in_ready=1 and Y=0.
- REQ-025 SHALL, on rst asserted mid-operation, discard any buffered words, including in FULL.
- REQ-026 SHALL treat a push or pop on the reset edge as having no effect.

Configuration
- REQ-027 SHALL support the macro INV_SKID_STAGE_STATS_EN; when defined, it adds output port push_cnt, 16 bits.
- REQ-028 SHALL, with the macro defined, increment push_cnt on every push and saturate it at 16'hFFFF; rst clears it to 0.
- REQ-029 SHALL, without the macro, have neither the push_cnt port nor the counter logic; all other behaviour is identical.

Verification
- REQ-030 SHALL pass the basic push scenario:
  - Stimulus: WIDTH=2, INV_A=2'b01, push A=2'b10 with out_ready=1.
  - Response: next cycle Y=2'b11 and out_valid=1.
- REQ-031 SHALL pass the backpressure scenario:
  - Stimulus: out_ready=0, push 2'b00 then 2'b01.
  - Response: state FULL and in_ready=0; a third in_valid is ignored.
  - Then release out_ready: Y delivers 2'b00 then 2'b01 (INV_A=0).
- REQ-032 SHALL pass the simultaneous push/pop scenario:
  - Stimulus: in ONE, push 2'b11 while popping.
  - Response: stays ONE, Y=2'b11 next cycle, in_ready stays 1.
- REQ-033 SHALL pass the reset-while-FULL scenario:
  - Stimulus: assert rst for one cycle while FULL.
  - Response: out_valid=0, in_ready=1, Y=0; no stale word is emitted afterwards.
- REQ-034 SHALL pass the streaming scenario:
  - Stimulus: 1000 random words with random in_valid/out_ready.
  - Response: the output sequence equals the input sequence XOR INV_A.
  - Throughput reaches 1 word/cycle when both handshakes are held high.
- REQ-035 SHALL pass the counter scenario:
  - Stimulus: with STATS_EN defined, 70000 pushes.
  - Response: push_cnt=16'hFFFF and holds; rst returns it to 0.
